inst_rom_loader: RTL and testbench



---
 rtl/inst_rom_loader_pkg.sv | 13 +
 rtl/inst_rom_loader_if.sv | 40 ++++
 rtl/inst_rom_loader_rom_byte_packer.sv | 42 ++++
 rtl/inst_rom_loader.sv | 98 +++++++++
 tb/tb_inst_rom_loader.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/inst_rom_loader_pkg.sv
// Shared types for the instruction ROM loader: fetch bus widths and loader FSM states.
package inst_rom_loader_pkg;

  typedef logic [31:0] inst_t;
  typedef logic [31:0] inst_addr_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2
  } rom_state_e;

endpackage

// File: rtl/inst_rom_loader_if.sv
// Load-stream and fetch-port bundle between PS/core (master) and the ROM loader (slave).
// INST_ROM_CHECKSUM_EN adds the chk_out XOR-of-words signal.
interface inst_rom_loader_if #(
  parameter int unsigned AddrWidth = 10
);
  import inst_rom_loader_pkg::*;

  logic                 load_start;
  logic [AddrWidth:0]   load_len;
  logic                 load_valid;
  logic [7:0]           load_byte;
  logic                 load_ready;
  logic                 load_done;
  logic                 core_rst;
  logic                 rom_en;
  inst_addr_t           rom_addr;
  inst_t                rom_data;
`ifdef INST_ROM_CHECKSUM_EN
  logic [31:0]          chk_out;

  modport master (
    output load_start, load_len, load_valid, load_byte, rom_en, rom_addr,
    input  load_ready, load_done, core_rst, rom_data, chk_out
  );
  modport slave (
    input  load_start, load_len, load_valid, load_byte, rom_en, rom_addr,
    output load_ready, load_done, core_rst, rom_data, chk_out
  );
`else
  modport master (
    output load_start, load_len, load_valid, load_byte, rom_en, rom_addr,
    input  load_ready, load_done, core_rst, rom_data
  );
  modport slave (
    input  load_start, load_len, load_valid, load_byte, rom_en, rom_addr,
    output load_ready, load_done, core_rst, rom_data
  );
`endif

endinterface

// File: rtl/inst_rom_loader_rom_byte_packer.sv
// Packs an MSB-first byte stream into 32-bit words; word_valid_o fires with the 4th byte.
module inst_rom_loader_rom_byte_packer
  import inst_rom_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_i,
  output logic       word_valid_o,
  output inst_t      word_o
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] sh_q, sh_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    sh_d       = sh_q;
    if (clear_i) begin
      byte_cnt_d = '0;
      sh_d       = '0;
    end else if (byte_valid_i) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      sh_d       = {sh_q[15:0], byte_i};
    end
  end

  assign word_valid_o = byte_valid_i && !clear_i && (byte_cnt_q == 2'd3);
  assign word_o       = {sh_q, byte_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      sh_q       <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      sh_q       <= sh_d;
    end
  end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction ROM loaded byte-serially by the PS while the core is held in reset, then serves
// zero-latency fetches. INST_ROM_CHECKSUM_EN adds an XOR checksum of the loaded words.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int unsigned AddrWidth = 10
) (
  input  logic              clk,
  input  logic              rst,
  inst_rom_loader_if.slave  bus
);

  localparam int unsigned        Depth    = 1 << AddrWidth;
  localparam logic [AddrWidth:0] DepthLen = (AddrWidth + 1)'(Depth);
  localparam logic [AddrWidth:0] OneLen   = (AddrWidth + 1)'(1);

  rom_state_e         state_q, state_d;
  logic [AddrWidth:0] len_q, len_d;
  logic [AddrWidth:0] word_cnt_q, word_cnt_d;
  inst_t              mem_q [Depth];

  logic  byte_accept;
  logic  word_valid;
  inst_t word;

  // A byte arriving together with load_start belongs to the aborted load.
  assign byte_accept = (state_q == StLoad) && bus.load_valid && !bus.load_start;

  inst_rom_loader_rom_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (bus.load_start),
    .byte_valid_i (byte_accept),
    .byte_i       (bus.load_byte),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    if (bus.load_start) begin
      len_d      = (bus.load_len > DepthLen) ? DepthLen : bus.load_len;
      word_cnt_d = '0;
      state_d    = (bus.load_len == '0) ? StRun : StLoad;
    end else if (word_valid) begin
      word_cnt_d = word_cnt_q + OneLen;
      if (word_cnt_d == len_q) state_d = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (word_valid) mem_q[word_cnt_q[AddrWidth-1:0]] <= word;
  end

  assign bus.load_ready = (state_q == StLoad);
  assign bus.load_done  = (state_q == StRun);
  assign bus.core_rst   = (state_q != StRun);

  logic [AddrWidth-1:0] idx;
  logic                 hi_set;
  logic                 in_range;
  logic                 unused_byte_off;

  assign idx             = bus.rom_addr[AddrWidth+1:2];
  assign hi_set          = |bus.rom_addr[31:AddrWidth+2];
  assign in_range        = ({1'b0, idx} < len_q);
  assign unused_byte_off = ^bus.rom_addr[1:0];
  assign bus.rom_data    = (bus.rom_en && !hi_set && in_range) ? mem_q[idx] : '0;

`ifdef INST_ROM_CHECKSUM_EN
  logic [31:0] chk_q;

  always_ff @(posedge clk) begin
    if (rst || bus.load_start) begin
      chk_q <= '0;
    end else if (word_valid) begin
      chk_q <= chk_q ^ word;
    end
  end

  assign bus.chk_out = chk_q;
`endif

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: directed steps plus randomized loads and fetches
// compared against a byte-queue/array reference model.
module tb_inst_rom_loader;
  import inst_rom_loader_pkg::*;

  localparam int unsigned AW    = 10;
  localparam int unsigned Depth = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_rom_loader_if #(.AddrWidth(AW)) bus ();

  inst_rom_loader #(.AddrWidth(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: phase 0 idle, 1 loading, 2 running.
  int          m_phase;
  int unsigned m_len;
  int unsigned m_words;
  logic [31:0] m_chk;
  logic [7:0]  m_q [$];
  logic [31:0] m_mem [Depth];
  bit          m_known [Depth];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".load_ready"}, 32'(bus.load_ready), 32'(m_phase == 1));
    check({tag, ".load_done"}, 32'(bus.load_done), 32'(m_phase == 2));
    check({tag, ".core_rst"}, 32'(bus.core_rst), 32'(m_phase != 2));
`ifdef INST_ROM_CHECKSUM_EN
    check({tag, ".chk_out"}, bus.chk_out, m_chk);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    m_phase = 0; m_len = 0; m_words = 0; m_chk = '0; m_q.delete();
    #1;
    rst = 1'b0;
    check_flags("reset");
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare flags.
  task automatic step(input bit st, input int unsigned len, input bit v, input logic [7:0] b);
    logic [31:0] w;
    @(negedge clk);
    bus.load_start = st;
    bus.load_len   = len[AW:0];
    bus.load_valid = v;
    bus.load_byte  = b;
    @(posedge clk);
    if (st) begin
      m_len   = (len > Depth) ? Depth : len;
      m_words = 0;
      m_chk   = '0;
      m_q.delete();
      m_phase = (m_len == 0) ? 2 : 1;
    end else if (m_phase == 1 && v) begin
      m_q.push_back(b);
      if (m_q.size() == 4) begin
        w = {m_q[0], m_q[1], m_q[2], m_q[3]};
        m_q.delete();
        m_mem[m_words]   = w;
        m_known[m_words] = 1'b1;
        m_chk            = m_chk ^ w;
        m_words++;
        if (m_words == m_len) m_phase = 2;
      end
    end
    #1;
    check_flags("step");
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
  endtask

  task automatic fetch_chk(input string tag, input bit en, input logic [31:0] addr,
                           input logic [31:0] exp);
    @(negedge clk);
    bus.rom_en   = en;
    bus.rom_addr = addr;
    #1;
    check(tag, bus.rom_data, exp);
  endtask

  task automatic fetch_model(input bit en, input logic [31:0] addr);
    int unsigned i;
    logic [31:0] exp;
    @(negedge clk);
    bus.rom_en   = en;
    bus.rom_addr = addr;
    #1;
    i = addr / 4;
    if (!en || addr >= 4 * Depth || i >= m_len) exp = '0;
    else if (m_known[i]) exp = m_mem[i];
    else return;
    check("fetch_rand", bus.rom_data, exp);
  endtask

  task automatic send_bytes(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 0, 1'b1, t[31:24]);
      t = t << 8;
    end
  endtask

  initial begin
    int unsigned l;
    int          guard;
    bit          v;
    int unsigned idx;
    logic [31:0] addr;

    for (int i = 0; i < Depth; i++) m_known[i] = 1'b0;
    bus.load_start = 1'b0;
    bus.load_len   = '0;
    bus.load_valid = 1'b0;
    bus.load_byte  = '0;
    bus.rom_en     = 1'b0;
    bus.rom_addr   = '0;
    rst            = 1'b0;

    do_reset();
    fetch_chk("fetch_after_reset", 1'b1, 32'h0, 32'h0);

    // Two-word program; last byte releases core reset on that edge.
    step(1'b1, 2, 1'b0, 8'h00);
    step(1'b0, 0, 1'b0, 8'h55);
    send_bytes(32'h34010010);
    send_bytes(32'h34020020);
    check("done_after_8", 32'(bus.load_done), 32'd1);
    fetch_chk("fetch_a0", 1'b1, 32'h0, 32'h34010010);
    fetch_chk("fetch_a4", 1'b1, 32'h4, 32'h34020020);
    fetch_chk("fetch_a6", 1'b1, 32'h6, 32'h34020020);
    fetch_chk("fetch_a8", 1'b1, 32'h8, 32'h0);
    fetch_chk("fetch_en0", 1'b0, 32'h4, 32'h0);
    fetch_chk("fetch_hibit", 1'b1, 32'h0000_1000, 32'h0);
`ifdef INST_ROM_CHECKSUM_EN
    check("chk_two_words", bus.chk_out, 32'h00030030);
`endif

    // Restart after 5 bytes; coincident byte dropped.
    step(1'b1, 2, 1'b0, 8'h00);
`ifdef INST_ROM_CHECKSUM_EN
    check("chk_cleared", bus.chk_out, 32'h0);
`endif
    for (int k = 0; k < 5; k++) step(1'b0, 0, 1'b1, 8'(8'hA0 + k));
    step(1'b1, 1, 1'b1, 8'hFF);
    send_bytes(32'h3C01ABCD);
    check("done_restart", 32'(bus.load_done), 32'd1);
    fetch_chk("fetch_restart0", 1'b1, 32'h0, 32'h3C01ABCD);
    fetch_chk("fetch_restart1", 1'b1, 32'h4, 32'h0);

    // Reload from run, then zero-length load.
    step(1'b1, 3, 1'b0, 8'h00);
    check("core_rst_reload", 32'(bus.core_rst), 32'd1);
    step(1'b1, 0, 1'b0, 8'h00);
    check("done_len0", 32'(bus.load_done), 32'd1);
    fetch_chk("fetch_len0", 1'b1, 32'h0, 32'h0);
    step(1'b0, 0, 1'b1, 8'h12);

    // Oversize length clamps to the full array.
    step(1'b1, 1500, 1'b0, 8'h00);
    for (int k = 0; k < 4 * Depth; k++) step(1'b0, 0, 1'b1, 8'($urandom));
    check("done_clamp", 32'(bus.load_done), 32'd1);
    fetch_model(1'b1, 32'(4 * (Depth - 1)));
    fetch_chk("fetch_clamp_top", 1'b1, 32'(4 * Depth), 32'h0);

    // Randomized loads with gaps and occasional restarts.
    for (int t = 0; t < 12; t++) begin
      l = $urandom_range(0, 6);
      guard = 0;
      step(1'b1, l, 1'b0, 8'h00);
      while (m_phase == 1 && guard < 400) begin
        v = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 59) == 0) step(1'b1, $urandom_range(1, 5), v, 8'($urandom));
        else step(1'b0, 0, v, 8'($urandom));
        guard++;
      end
      check("load_finished", 32'(bus.load_done), 32'd1);
      for (int f = 0; f < 8; f++) begin
        idx  = $urandom_range(0, m_len + 1);
        addr = 32'(idx * 4 + $urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) addr = addr | (32'h1 << $urandom_range(12, 31));
        fetch_model($urandom_range(0, 7) != 0, addr);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
